// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter: queue entry layout,
// default sizing, port indices and grant encoding.
package wb_pkg;
  localparam int FIFO_DEPTH_DEF   = 2;
  localparam int STARVE_LIMIT_DEF = 3;

  localparam int NUM_PORTS = 2;
  localparam int PORT_EXU  = 0;
  localparam int PORT_LSU  = 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  typedef logic [1:0] gnt_t;
  localparam gnt_t GNT_NONE = 2'd0;
  localparam gnt_t GNT_EXU  = 2'd1;
  localparam gnt_t GNT_LSU  = 2'd2;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: two requester ports (EXU, LSU) in, one register-file write port out.
interface wb_arbiter_if;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        waw_err;

  modport slave (
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    output exu_ready, lsu_ready, rf_rd, rf_data, waw_err
  );

  modport master (
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    input  exu_ready, lsu_ready, rf_rd, rf_data, waw_err
  );
endinterface

// File: rtl/wb_fifo.sv
// Per-requester writeback queue: power-of-two depth, synchronous reset,
// head visible combinationally from registered storage.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t din_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  // A full queue still takes a push when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queues EXU and LSU results, grants one head per cycle
// (LSU first, EXU forced after STARVE_LIMIT losses) and flags same-rd heads.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

  logic      [NUM_PORTS-1:0] vld, rdy, push, pop, full, empty, hv;
  wb_entry_t [NUM_PORTS-1:0] in_ent, head;
  gnt_t                      gnt;
  wb_entry_t                 wr;
  logic [SW-1:0]             starve_q, starve_d;

  assign vld              = {bus.lsu_valid, bus.exu_valid};
  assign in_ent[PORT_EXU] = '{rd: bus.exu_rd, data: bus.exu_data};
  assign in_ent[PORT_LSU] = '{rd: bus.lsu_rd, data: bus.lsu_data};

  // rd==0 transfers complete the handshake but never occupy a slot.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign rdy[p]  = rst_n && !full[p];
    assign push[p] = vld[p] && rdy[p] && (in_ent[p].rd != '0);
    assign hv[p]   = !empty[p];

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push[p]),
      .din_i  (in_ent[p]),
      .pop_i  (pop[p]),
      .full_o (full[p]),
      .empty_o(empty[p]),
      .head_o (head[p])
    );
  end

  always_comb begin
    gnt = GNT_NONE;
    if (hv[PORT_EXU] && starve_q == SMAX) gnt = GNT_EXU;
    else if (hv[PORT_LSU])                gnt = GNT_LSU;
    else if (hv[PORT_EXU])                gnt = GNT_EXU;
  end

  assign pop[PORT_EXU] = (gnt == GNT_EXU);
  assign pop[PORT_LSU] = (gnt == GNT_LSU);

  // Counts consecutive cycles the EXU head lost to LSU.
  always_comb begin
    starve_d = starve_q;
    if (!hv[PORT_EXU] || gnt == GNT_EXU)           starve_d = '0;
    else if (gnt == GNT_LSU && starve_q != SMAX)   starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  always_comb begin
    wr = '0;
    case (gnt)
      GNT_EXU: wr = head[PORT_EXU];
      GNT_LSU: wr = head[PORT_LSU];
      default: ;
    endcase
  end

  assign bus.exu_ready = rdy[PORT_EXU];
  assign bus.lsu_ready = rdy[PORT_LSU];
  assign bus.rf_rd     = wr.rd;
  assign bus.rf_data   = wr.data;
  assign bus.waw_err   = &hv && (head[PORT_EXU].rd == head[PORT_LSU].rd) &&
                         (head[PORT_EXU].rd != '0);
endmodule
